// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between byte sources, uart_tx_arbiter and uart_tx.
// slave: the arbiter; master: the clients together with the uart_tx transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OWNER_W = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 busy;
    logic [OWNER_W-1:0]   owner;
    logic                 err;

    modport slave (
        input  req, req_data, tx_busy, tx_done,
        output gnt, ack, tx_start, tx_data, busy, owner, err
    );

    modport master (
        output req, req_data, tx_busy, tx_done,
        input  gnt, ack, tx_start, tx_data, busy, owner, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned OWNER_W        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    if (OWNER_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2)
    begin : g_bad_cfg
        $error("uart_tx_arbiter: inconsistent parameters");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

    state_e             state_q;
    logic [OWNER_W-1:0] last_owner_q;
    logic [OWNER_W-1:0] owner_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic               busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_cnt_q;
    logic            err_q;
`endif

    // Scan starts just after the previous owner so every source gets a turn.
    logic               winner_valid;
    logic [OWNER_W-1:0] winner;

    always_comb begin
        int unsigned idx;
        idx          = 0;
        winner_valid = 1'b0;
        winner       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_owner_q) + k) % NUM_REQ;
            if (!winner_valid && bus.req[idx]) begin
                winner_valid = 1'b1;
                winner       = OWNER_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_owner_q <= OWNER_W'(NUM_REQ - 1);
            owner_q      <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            ack_q      <= '0;
            tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (winner_valid) begin
                        gnt_q     <= NUM_REQ'(1) << winner;
                        owner_q   <= winner;
                        tx_data_q <= bus.req_data[{winner, 3'b000} +: 8];
                        busy_q    <= 1'b1;
                        state_q   <= StStart;
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                StStart: begin
                    tx_start_q <= 1'b1;
                    state_q    <= StWaitBusy;
                end
                StWaitBusy, StWaitDone: begin
                    // A done seen before busy still counts as a finished frame.
                    if (bus.tx_done) begin
                        ack_q        <= NUM_REQ'(1) << owner_q;
                        gnt_q        <= '0;
                        last_owner_q <= owner_q;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        err_q        <= 1'b1;
                        gnt_q        <= '0;
                        last_owner_q <= owner_q;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
`endif
                    else begin
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
                        if (state_q == StWaitBusy && bus.tx_busy) begin
                            state_q <= StWaitDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a small uart_tx behavioural model.
module tb_uart_tx_arbiter;

    localparam int unsigned FRAME = 8;
    localparam int unsigned TMO   = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .OWNER_W(2)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .OWNER_W       (2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // uart_tx model: busy for FRAME cycles after tx_start, then a one-cycle done.
    logic m_busy;
    logic m_done;
    int   m_cnt;
    bit   model_on = 1'b1;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (bus.tx_start && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= FRAME;
            end else if (m_busy && model_on) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign bus.tx_busy = m_busy;
    assign bus.tx_done = m_done;

    // Protocol monitors, reviewed once at the end of the run.
    int         cyc = 0;
    int         done_cyc = -10;
    bit         pending = 1'b0;
    logic [3:0] last_gnt = '0;
    int         viol_overlap = 0;
    int         viol_start_busy = 0;
    int         viol_onehot = 0;
    int         viol_ack_bit = 0;
    int         viol_ack_lat = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            if (bus.tx_done) done_cyc <= cyc;
            if (bus.tx_start) begin
                if (pending) viol_overlap <= viol_overlap + 1;
                pending <= 1'b1;
            end else if (bus.tx_done) begin
                pending <= 1'b0;
            end
            if (bus.tx_start && bus.tx_busy) viol_start_busy <= viol_start_busy + 1;
            if (!$onehot0(bus.gnt) || !$onehot0(bus.ack)) viol_onehot <= viol_onehot + 1;
            if (|bus.gnt) last_gnt <= bus.gnt;
            if (|bus.ack && bus.ack != last_gnt) viol_ack_bit <= viol_ack_bit + 1;
            if (|bus.ack && cyc != done_cyc + 1) viol_ack_lat <= viol_ack_lat + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.gnt, bus.ack, bus.tx_start, bus.tx_data, bus.busy, bus.owner, bus.err};
    endfunction

    task automatic do_reset();
        bus.req = '0;
        reset   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_busy) break;
            tick();
        end
        chk("tx_busy_seen", 32'(bus.tx_busy), 32'd1);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (|bus.ack) break;
        end
    endtask

    task automatic count_acks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (|bus.ack) n++;
        end
    endtask

    typedef struct {
        bit          do_rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  byte_exp;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v);
        if (v.do_rst) do_reset();
        bus.req      = v.req;
        bus.req_data = v.data;
        tick();
        chk("gnt", 32'(bus.gnt), 32'(v.gnt));
        chk("owner", 32'(bus.owner), 32'(v.owner));
        chk("busy_on", 32'(bus.busy), 32'd1);
        tick();
        chk("tx_start", 32'(bus.tx_start), 32'd1);
        chk("tx_data", 32'(bus.tx_data), 32'(v.byte_exp));
        tick();
        chk("tx_start_pulse", 32'(bus.tx_start), 32'd0);
        wait_ack();
        chk("ack", 32'(bus.ack), 32'(v.gnt));
        chk("idle_after_ack", 32'({bus.gnt, bus.busy}), 32'd0);
    endtask

    int n;

    initial begin
        reset        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        tick();
        tick();
        chk("reset_outs", 32'(outs()), 32'd0);

        vecs[0]  = '{1'b1, 4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
        vecs[1]  = '{1'b1, 4'b1111, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vecs[2]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vecs[3]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0100, 2'd2, 8'h33};
        vecs[4]  = '{1'b0, 4'b1111, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        vecs[5]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vecs[6]  = '{1'b0, 4'b0010, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vecs[7]  = '{1'b0, 4'b0011, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vecs[8]  = '{1'b0, 4'b0011, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vecs[9]  = '{1'b0, 4'b0110, 32'h44332211, 4'b0100, 2'd2, 8'h33};
        vecs[10] = '{1'b0, 4'b1001, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        vecs[11] = '{1'b0, 4'b1001, 32'h44332211, 4'b0001, 2'd0, 8'h11};

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        bus.req = '0;
        tick();

        // Requester drops req and changes data mid-frame; latched byte must survive.
        bus.req      = 4'b0100;
        bus.req_data = 32'h005A0000;
        tick();
        chk("late_gnt", 32'(bus.gnt), 32'b0100);
        tick();
        chk("late_start", 32'({bus.tx_start, bus.tx_data}), 32'h15A);
        wait_busy();
        bus.req      = '0;
        bus.req_data = 32'hFFFFFFFF;
        wait_ack();
        chk("late_ack", 32'(bus.ack), 32'b0100);
        chk("late_data_held", 32'(bus.tx_data), 32'h5A);
        tick();
        chk("late_ack_one_cycle", 32'(bus.ack), 32'd0);
        chk("owner_held", 32'(bus.owner), 32'd2);

        // Reset while waiting for tx_done aborts the frame silently.
        bus.req      = 4'b0010;
        bus.req_data = 32'h0000BB00;
        tick();
        chk("rst_mid_gnt", 32'(bus.gnt), 32'b0010);
        tick();
        bus.req = '0;
        wait_busy();
        reset = 1'b0;
        tick();
        chk("rst_mid_outs", 32'(outs()), 32'd0);
        reset = 1'b1;
        count_acks(20, n);
        chk("rst_mid_no_ack", 32'(n), 32'd0);
        bus.req      = 4'b1000;
        bus.req_data = 32'hCC000000;
        tick();
        chk("post_rst_gnt", 32'({bus.gnt, bus.owner}), 32'b1000_11);
        tick();
        chk("post_rst_start", 32'({bus.tx_start, bus.tx_data}), 32'h1CC);
        bus.req = '0;
        wait_ack();
        chk("post_rst_ack", 32'(bus.ack), 32'b1000);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never finishes: watchdog fires TMO cycles after tx_start.
        model_on     = 1'b0;
        bus.req      = 4'b0001;
        bus.req_data = 32'h000000A5;
        tick();
        chk("tmo_gnt", 32'(bus.gnt), 32'b0001);
        tick();
        chk("tmo_start", 32'(bus.tx_start), 32'd1);
        bus.req = '0;
        n = 0;
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            tick();
            if (bus.err) begin
                n = i;
                break;
            end
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_released", 32'({bus.gnt, bus.ack, bus.busy}), 32'd0);
        tick();
        chk("tmo_err_pulse", 32'(bus.err), 32'd0);
        model_on = 1'b1;
        count_acks(15, n);
        chk("tmo_late_done_no_ack", 32'(n), 32'd0);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
        bus.req      = 4'b0010;
        bus.req_data = 32'h00007700;
        tick();
        chk("tmo_next_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        wait_ack();
        chk("tmo_next_ack", 32'(bus.ack), 32'b0010);
`else
        chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

        tick();
        chk("inv_no_overlap", 32'(viol_overlap), 32'd0);
        chk("inv_start_not_busy", 32'(viol_start_busy), 32'd0);
        chk("inv_onehot", 32'(viol_onehot), 32'd0);
        chk("inv_ack_on_gnt", 32'(viol_ack_bit), 32'd0);
        chk("inv_ack_latency", 32'(viol_ack_lat), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
